// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage data-memory access sequencer (dreq/dresp handshake, load extend, store lane encode)
module mem_access_unit (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [2:0]  ls_flag,
  input  logic        mem_write_en,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        addr_error,
  output logic        dreq_valid,
  output logic [31:0] dreq_addr,
  output logic [2:0]  dreq_size,
  output logic [3:0]  dreq_strobe,
  output logic [31:0] dreq_data,
  input  logic        dresp_addr_ok,
  input  logic        dresp_data_ok,
  input  logic [31:0] dresp_data
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [2:0] LS_NONE    = 3'd0;
  localparam logic [2:0] LS_BTYE    = 3'd1;
  localparam logic [2:0] LS_BTYE_U  = 3'd2;
  localparam logic [2:0] LS_HALFW   = 3'd3;
  localparam logic [2:0] LS_HALFW_U = 3'd4;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [2:0]  flag_q;
  logic        we_q;
  logic        err_q;

  logic        accept;
  logic        misaligned;
  logic        complete;
  logic [15:0] lane;
  logic [31:0] load_val;
  logic [2:0]  size_enc;
  logic [3:0]  strobe_enc;
  logic [31:0] data_enc;

  assign accept   = ((state == S_IDLE) || (state == S_DONE)) && start && (ls_flag != LS_NONE);
  assign complete = ((state == S_REQ) && dresp_addr_ok && dresp_data_ok) ||
                    ((state == S_WAIT) && dresp_data_ok);

  // Alignment check on the incoming request; codes above LS_WORD are treated as word accesses
  always_comb begin
    misaligned = 1'b0;
    case (ls_flag)
      LS_BTYE, LS_BTYE_U:   misaligned = 1'b0;
      LS_HALFW, LS_HALFW_U: misaligned = addr[0];
      default:              misaligned = (addr[1:0] != 2'b00);
    endcase
  end

  // Next-state logic; a misaligned access skips the bus and goes straight to DONE
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (accept) state_nxt = misaligned ? S_DONE : S_REQ;
        else        state_nxt = S_IDLE;
      end
      S_REQ:   if (dresp_addr_ok) state_nxt = dresp_data_ok ? S_DONE : S_WAIT;
      S_WAIT:  if (dresp_data_ok) state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Latch the request fields of an aligned access so dreq_* stay stable through the handshake
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      flag_q  <= LS_NONE;
      we_q    <= 1'b0;
    end else if (accept && !misaligned) begin
      addr_q  <= addr;
      wdata_q <= wdata;
      flag_q  <= ls_flag;
      we_q    <= mem_write_en;
    end
  end

  // Result and error capture for the DONE cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else if (accept) begin
      rdata_q <= 32'd0;
      err_q   <= misaligned;
    end else if (complete) begin
      rdata_q <= load_val;
    end
  end

  assign lane = 16'(dresp_data >> {addr_q[1:0], 3'b000});

  // Load extraction from the raw bus word; stores report zero
  always_comb begin
    load_val = dresp_data;
    case (flag_q)
      LS_BTYE:    load_val = {{24{lane[7]}}, lane[7:0]};
      LS_BTYE_U:  load_val = {24'd0, lane[7:0]};
      LS_HALFW:   load_val = {{16{lane[15]}}, lane[15:0]};
      LS_HALFW_U: load_val = {16'd0, lane[15:0]};
      default:    load_val = dresp_data;
    endcase
    if (we_q) load_val = 32'd0;
  end

  // Store lane encoding: size, byte strobes and lane-replicated data
  always_comb begin
    size_enc   = 3'd2;
    strobe_enc = 4'b1111;
    data_enc   = wdata_q;
    case (flag_q)
      LS_BTYE, LS_BTYE_U: begin
        size_enc   = 3'd0;
        strobe_enc = 4'b0001 << addr_q[1:0];
        data_enc   = {4{wdata_q[7:0]}};
      end
      LS_HALFW, LS_HALFW_U: begin
        size_enc   = 3'd1;
        strobe_enc = 4'b0011 << addr_q[1:0];
        data_enc   = {2{wdata_q[15:0]}};
      end
      default: begin
        size_enc   = 3'd2;
        strobe_enc = 4'b1111;
        data_enc   = wdata_q;
      end
    endcase
    if (!we_q) strobe_enc = 4'b0000;
  end

  assign dreq_valid  = (state == S_REQ);
  assign dreq_addr   = dreq_valid ? addr_q : 32'd0;
  assign dreq_size   = dreq_valid ? size_enc : 3'd0;
  assign dreq_strobe = dreq_valid ? strobe_enc : 4'b0000;
  assign dreq_data   = dreq_valid ? data_enc : 32'd0;

  assign done       = (state == S_DONE);
  assign addr_error = done && err_q;
  assign rdata      = done ? rdata_q : 32'd0;
  assign busy       = (state == S_REQ) || (state == S_WAIT) || (accept && !misaligned);

endmodule
